fir_stream_driver: RTL and testbench

Initiator side of the FIR core's sample handshake. Accepts samples on a valid/ready stream and drives the core's input_valid/data_in strobe sequence. Waits for the core's one-cycle output_valid pulse and buffers each result into a small output FIFO presented as a valid/ready stream. Sits between the upstream sample source and the FIR core at the filter top level.

---
 rtl/fir_stream_pkg.sv | 20 ++
 rtl/fir_out_fifo.sv | 69 ++++++
 rtl/fir_stream_driver.sv | 159 +++++++++++++++
 tb/tb_fir_stream_driver.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_stream_pkg.sv
// Shared types and default widths for the FIR stream driver and its output FIFO.
package fir_stream_pkg;

    // Driver FSM: idle, strobing input_valid, waiting for the core's result
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_OUT_WIDTH  = 40;

    // Width of the result counter; wraps naturally at 2^16
    localparam int SAMPLE_CNT_W   = 16;

    // Pulse counter covers VALID_PULSE values 1..15
    localparam int PULSE_CNT_W    = 4;

endpackage

// File: rtl/fir_out_fifo.sv
// Small synchronous result FIFO. Head entry is presented combinationally on dout.
module fir_out_fifo
    import fir_stream_pkg::*;
#(
    parameter  int OUT_WIDTH  = DEF_OUT_WIDTH,
    parameter  int OBUF_DEPTH = 2,
    localparam int PTR_W      = $clog2(OBUF_DEPTH),
    localparam int CNT_W      = PTR_W + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic [OUT_WIDTH-1:0] din,
    output logic [OUT_WIDTH-1:0] dout,
    output logic                 empty,
    output logic                 full,
    output logic [CNT_W-1:0]     count
);

    logic [OUT_WIDTH-1:0] mem_q [OBUF_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic [CNT_W-1:0]     count_d;
    logic                 do_push;
    logic                 do_pop;

    // A pop frees a slot in the same cycle, so a full FIFO may still push then
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Occupancy update; simultaneous push and pop leaves it unchanged
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage and pointers; reset clears contents as well as occupancy
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < OBUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(OBUF_DEPTH));
    assign count = count_q;

endmodule

// File: rtl/fir_stream_driver.sv
// Initiator for the FIR core's sample handshake: takes one sample at a time from
// a valid/ready stream, strobes it into the core, waits for the result strobe and
// queues results into a small FIFO presented as a valid/ready stream.
// The FIR core itself must be reset with its active-high rst tied to ~rst so that
// both sides abort together.
module fir_stream_driver
    import fir_stream_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
    parameter int VALID_PULSE = 1,
    parameter int TIMEOUT     = 512,
    parameter int OBUF_DEPTH  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_WIDTH-1:0]   s_data,
    output logic                    fir_input_valid,
    output logic [DATA_WIDTH-1:0]   fir_data_in,
    input  logic                    fir_output_valid,
    input  logic [OUT_WIDTH-1:0]    fir_data_out,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [OUT_WIDTH-1:0]    m_data,
    output logic                    busy,
    output logic                    timeout_err,
    output logic                    protocol_err,
    output logic [SAMPLE_CNT_W-1:0] sample_cnt
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int CNT_W  = $clog2(OBUF_DEPTH) + 1;

    state_e                  state_q, state_d;
    logic [PULSE_CNT_W-1:0]  pulse_cnt_q, pulse_cnt_d;
    logic [WAIT_W-1:0]       wait_cnt_q, wait_cnt_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [SAMPLE_CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic                    timeout_err_q, timeout_err_d;
    logic                    protocol_err_q, protocol_err_d;

    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic [CNT_W-1:0]        fifo_count;
    logic [OUT_WIDTH-1:0]    fifo_dout;
    logic                    s_accept;

    // Only one sample is ever in flight, so a free slot at acceptance is
    // guaranteed to still be free when its result arrives.
    assign s_ready  = (state_q == ST_IDLE) && (fifo_count < CNT_W'(OBUF_DEPTH));
    assign s_accept = s_valid && s_ready;
    assign fifo_pop = !fifo_empty && m_ready;

    // Next-state logic for the handshake FSM, counters, result push and error flags
    always_comb begin
        state_d        = state_q;
        pulse_cnt_d    = pulse_cnt_q;
        wait_cnt_d     = wait_cnt_q;
        data_d         = data_q;
        sample_cnt_d   = sample_cnt_q;
        timeout_err_d  = timeout_err_q;
        protocol_err_d = protocol_err_q;
        fifo_push      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (s_accept) begin
                    data_d      = s_data;
                    pulse_cnt_d = '0;
                    state_d     = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (pulse_cnt_q == PULSE_CNT_W'(VALID_PULSE - 1)) begin
                    wait_cnt_d = '0;
                    state_d    = ST_WAIT;
                end else begin
                    pulse_cnt_d = pulse_cnt_q + 1'b1;
                end
            end
            ST_WAIT: begin
                // A strobe on the final wait cycle still counts as a result
                if (fir_output_valid) begin
                    // The full check only matters if the slot guarantee were broken
                    if (!fifo_full || fifo_pop) begin
                        fifo_push    = 1'b1;
                        sample_cnt_d = sample_cnt_q + 1'b1;
                    end
                    state_d = ST_IDLE;
                end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The core should only answer while a sample is outstanding
        if (fir_output_valid && (state_q != ST_WAIT)) begin
            protocol_err_d = 1'b1;
        end
    end

    // State and datapath registers; reset aborts any in-flight sample
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            pulse_cnt_q    <= '0;
            wait_cnt_q     <= '0;
            data_q         <= '0;
            sample_cnt_q   <= '0;
            timeout_err_q  <= 1'b0;
            protocol_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pulse_cnt_q    <= pulse_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            data_q         <= data_d;
            sample_cnt_q   <= sample_cnt_d;
            timeout_err_q  <= timeout_err_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    fir_out_fifo #(
        .OUT_WIDTH  (OUT_WIDTH),
        .OBUF_DEPTH (OBUF_DEPTH)
    ) u_out_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fir_data_out),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    // The core latches the sample after input_valid falls, so data_q stays
    // stable from acceptance through the whole wait.
    assign fir_input_valid = (state_q == ST_DRIVE);
    assign fir_data_in     = data_q;
    assign busy            = (state_q != ST_IDLE);
    assign m_valid         = !fifo_empty;
    assign m_data          = fifo_dout;
    assign timeout_err     = timeout_err_q;
    assign protocol_err    = protocol_err_q;
    assign sample_cnt      = sample_cnt_q;

endmodule

// File: tb/tb_fir_stream_driver.sv
// Directed bench for fir_stream_driver with a behavioural FIR core model and a
// result scoreboard.
module tb_fir_stream_driver;

    localparam int MODEL_DELAY = 132;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = 16'h0;
    logic        m_ready = 1'b0;
    logic        spur = 1'b0;
    logic        model_en = 1'b1;

    logic        s_ready;
    logic        fir_input_valid;
    logic [15:0] fir_data_in;
    logic        fir_output_valid;
    logic [39:0] fir_data_out;
    logic        m_valid;
    logic [39:0] m_data;
    logic        busy;
    logic        timeout_err;
    logic        protocol_err;
    logic [15:0] sample_cnt;

    logic        model_strobe = 1'b0;
    logic        iv_prev = 1'b0;
    int          m_cnt = 0;

    logic [39:0] sb [$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          n;
    logic        hold_bad;
    logic        early;

    function automatic logic [39:0] fir_f(input logic [15:0] s);
        return (40'(s) << 8) + 40'h234;
    endfunction

    fir_stream_driver dut (
        .clk              (clk),
        .rst              (rst),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .s_data           (s_data),
        .fir_input_valid  (fir_input_valid),
        .fir_data_in      (fir_data_in),
        .fir_output_valid (fir_output_valid),
        .fir_data_out     (fir_data_out),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .m_data           (m_data),
        .busy             (busy),
        .timeout_err      (timeout_err),
        .protocol_err     (protocol_err),
        .sample_cnt       (sample_cnt)
    );

    always #5 clk = ~clk;

    // FIR core model: one-cycle result strobe on the MODEL_DELAY-th cycle after input_valid falls
    assign fir_output_valid = model_strobe | spur;
    assign fir_data_out     = model_strobe ? fir_f(fir_data_in) : 40'h0;

    always @(negedge clk) begin
        model_strobe = 1'b0;
        if (!rst || !model_en) m_cnt = 0;
        else if (iv_prev && !fir_input_valid) m_cnt = 1;
        else if (m_cnt > 0) m_cnt = m_cnt + 1;
        if (m_cnt == MODEL_DELAY) begin
            model_strobe = 1'b1;
            m_cnt = 0;
        end
        iv_prev = fir_input_valid;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: score any pop / record any accept the DUT is about to see, then advance
    task automatic tick();
        if (rst && m_valid && m_ready) begin
            if (sb.size() == 0) chk("sb_unexpected_pop", 64'(1), 0);
            else chk("sb_order", 64'(m_data), 64'(sb.pop_front()));
        end
        if (rst && s_valid && s_ready && model_en) sb.push_back(fir_f(s_data));
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d);
        int k = 0;
        s_data  = d;
        s_valid = 1'b1;
        while (!s_ready && k < 2000) begin
            tick();
            k++;
        end
        chk("send_ready", 64'(s_ready), 1);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 2000) begin
            tick();
            k++;
        end
        chk("wait_idle_bound", 64'(busy), 0);
    endtask

    initial begin
        // reset state
        rst = 1'b0;
        repeat (3) tick();
        chk("rst_fir_iv", 64'(fir_input_valid), 0);
        chk("rst_m_valid", 64'(m_valid), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_s_ready", 64'(s_ready), 1);
        chk("rst_errs", 64'({timeout_err, protocol_err}), 0);
        chk("rst_cnt", 64'(sample_cnt), 0);
        chk("rst_fir_data", 64'(fir_data_in), 0);
        chk("rst_m_data", 64'(m_data), 0);
        rst = 1'b1;
        tick();

        // 1: nominal sample
        s_data = 16'h0010;
        s_valid = 1'b1;
        chk("t1_s_ready", 64'(s_ready), 1);
        tick();
        s_valid = 1'b0;
        chk("t1_iv_high", 64'(fir_input_valid), 1);
        chk("t1_fir_data", 64'(fir_data_in), 16'h0010);
        chk("t1_busy", 64'(busy), 1);
        chk("t1_s_ready_busy", 64'(s_ready), 0);
        tick();
        chk("t1_iv_one_cycle", 64'(fir_input_valid), 0);
        hold_bad = 1'b0;
        n = 0;
        while (!m_valid && n < 1000) begin
            if (fir_data_in !== 16'h0010 || fir_input_valid !== 1'b0) hold_bad = 1'b1;
            tick();
            n++;
        end
        chk("t1_data_hold", 64'(hold_bad), 0);
        chk("t1_m_valid", 64'(m_valid), 1);
        chk("t1_latency", 64'(fir_output_valid), 1);
        chk("t1_m_data", 64'(m_data), 40'h00_0000_1234);
        chk("t1_sample_cnt", 64'(sample_cnt), 1);
        chk("t1_idle", 64'(busy), 0);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("t1_drained", 64'(m_valid), 0);

        // 2: backpressure with a 2-entry FIFO
        send(16'h0021);
        wait_idle();
        chk("t2_one_ready", 64'(s_ready), 1);
        send(16'h0032);
        wait_idle();
        chk("t2_full_ready", 64'(s_ready), 0);
        chk("t2_head", 64'(m_data), 64'(fir_f(16'h0021)));
        s_data = 16'h0043;
        s_valid = 1'b1;
        repeat (3) tick();
        chk("t2_blocked_ready", 64'(s_ready), 0);
        chk("t2_blocked_busy", 64'(busy), 0);
        m_ready = 1'b1;
        send(16'h0043);
        wait_idle();
        tick();
        m_ready = 1'b0;
        chk("t2_empty", 64'(m_valid), 0);
        chk("t2_sb_drained", 64'(sb.size()), 0);
        chk("t2_sample_cnt", 64'(sample_cnt), 4);

        // 3: timeout, core never answers
        model_en = 1'b0;
        send(16'h0054);
        tick();
        chk("t3_in_wait", 64'(fir_input_valid), 0);
        early = 1'b0;
        n = 0;
        while (busy && n < 1000) begin
            if (timeout_err) early = 1'b1;
            tick();
            n++;
        end
        chk("t3_wait_cycles", 64'(n), 512);
        chk("t3_not_early", 64'(early), 0);
        chk("t3_timeout_err", 64'(timeout_err), 1);
        chk("t3_no_push", 64'(m_valid), 0);
        chk("t3_s_ready", 64'(s_ready), 1);
        chk("t3_sample_cnt", 64'(sample_cnt), 4);
        chk("t3_no_proto", 64'(protocol_err), 0);
        model_en = 1'b1;

        // 4: spurious strobe while idle
        spur = 1'b1;
        tick();
        spur = 1'b0;
        chk("t4_protocol_err", 64'(protocol_err), 1);
        chk("t4_sample_cnt", 64'(sample_cnt), 4);
        chk("t4_no_push", 64'(m_valid), 0);
        tick();
        chk("t4_still_empty", 64'(m_valid), 0);

        // 6: push and pop on the same edge
        send(16'h0065);
        wait_idle();
        chk("t6_one_entry", 64'(m_valid), 1);
        send(16'h0076);
        n = 0;
        while (!fir_output_valid && n < 1000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("t6_strobe_seen", 64'(fir_output_valid), 1);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("t6_m_valid", 64'(m_valid), 1);
        chk("t6_new_head", 64'(m_data), 64'(fir_f(16'h0076)));
        chk("t6_not_full", 64'(s_ready), 1);
        chk("t6_sample_cnt", 64'(sample_cnt), 6);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("t6_empty", 64'(m_valid), 0);
        chk("t6_sb_drained", 64'(sb.size()), 0);

        // 5: reset with a sample in WAIT and one result queued
        send(16'h0087);
        wait_idle();
        chk("t5_one_entry", 64'(m_valid), 1);
        send(16'h0098);
        repeat (10) tick();
        chk("t5_in_flight", 64'(busy), 1);
        rst = 1'b0;
        tick();
        chk("t5_fir_iv", 64'(fir_input_valid), 0);
        chk("t5_m_valid", 64'(m_valid), 0);
        chk("t5_busy", 64'(busy), 0);
        chk("t5_s_ready", 64'(s_ready), 1);
        chk("t5_errs", 64'({timeout_err, protocol_err}), 0);
        chk("t5_sample_cnt", 64'(sample_cnt), 0);
        rst = 1'b1;
        sb.delete();
        tick();

        // recovery after reset
        send(16'h8001);
        wait_idle();
        chk("t7_m_data", 64'(m_data), 64'(fir_f(16'h8001)));
        chk("t7_no_proto", 64'(protocol_err), 0);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("t7_sample_cnt", 64'(sample_cnt), 1);
        chk("t7_sb_drained", 64'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
